// File: rtl/imem_pkg.sv
// imem_pkg: geometry shared with the instruction memory read port and the loader state encoding.
package imem_pkg;
  localparam int DEPTH  = 256;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 8;
  typedef logic [2:0] loaderState_t;
  localparam loaderState_t LD_IDLE   = 3'd0;
  localparam loaderState_t LD_LEN_HI = 3'd1;
  localparam loaderState_t LD_LEN_LO = 3'd2;
  localparam loaderState_t LD_DATA   = 3'd3;
  localparam loaderState_t LD_DONE   = 3'd4;
  localparam loaderState_t LD_ERROR  = 3'd5;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: packs four big-endian stream bytes into one word and strobes on the fourth.
import imem_pkg::*;
module byte_packer (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byteEn,
  input  logic [7:0]        byteIn,
  output logic [WORD_W-1:0] word,
  output logic              wordValid
);
  logic [1:0]  laneCnt;
  logic [23:0] partial;
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      laneCnt <= '0;
      partial <= '0;
    end else if (byteEn) begin
      laneCnt <= laneCnt + 2'd1;
      partial <= {partial[15:0], byteIn};
    end
  end
  // The fourth byte is combined combinationally so the store write lands on the same edge.
  assign word      = {partial, byteIn};
  assign wordValid = byteEn && laneCnt == 2'd3;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed big-endian word stream, fills the instruction store
// and holds the CPU in reset until a load completes.
import imem_pkg::*;
module imem_loader (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  output logic [0:DEPTH*WORD_W-1]    instructionMemory_data,
  output logic                       cpu_hold,
  output logic                       done,
  output logic                       error,
  output logic [ADDR_W:0]            words_loaded
);
  loaderState_t      state;
  logic [7:0]        lenHi;
  logic [ADDR_W:0]   lenWords;
  logic [ADDR_W:0]   wordsLoaded;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] word;
  logic              wordValid;
  logic              startOk;
  logic              xfer;
  logic [15:0]       lenFull;
  logic              badLen;
  assign startOk = start && (state == LD_IDLE || state == LD_DONE || state == LD_ERROR);
  assign xfer    = byte_valid && byte_ready;
  assign lenFull = {lenHi, byte_data};
  assign badLen  = lenFull == 16'd0 || lenFull > 16'(DEPTH);
  byte_packer packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (startOk),
    .byteEn   (xfer && state == LD_DATA),
    .byteIn   (byte_data),
    .word     (word),
    .wordValid(wordValid)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= LD_IDLE;
      lenHi       <= '0;
      lenWords    <= '0;
      wordsLoaded <= '0;
    end else if (startOk) begin
      state       <= LD_LEN_HI;
      wordsLoaded <= '0;
    end else if (xfer) begin
      if (state == LD_LEN_HI) begin
        lenHi <= byte_data;
        state <= LD_LEN_LO;
      end else if (state == LD_LEN_LO) begin
        lenWords <= lenFull[ADDR_W:0];
        state    <= badLen ? LD_ERROR : LD_DATA;
      end else if (wordValid) begin
        wordsLoaded <= wordsLoaded + 1'b1;
        state       <= (wordsLoaded + 1'b1 == lenWords) ? LD_DONE : LD_DATA;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || startOk) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (wordValid) begin
      mem[wordsLoaded[ADDR_W-1:0]] <= word;
    end
  end
  // Ascending flat bus: the lowest flat index of each slot carries instruction bit 31.
  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign instructionMemory_data[i*WORD_W +: WORD_W] = mem[i];
  end
  assign byte_ready   = state == LD_LEN_HI || state == LD_LEN_LO || state == LD_DATA;
  assign cpu_hold     = state != LD_DONE;
  assign done         = state == LD_DONE;
  assign error        = state == LD_ERROR;
  assign words_loaded = wordsLoaded;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random-stall stream loads compared against an expected-image model.
import imem_pkg::*;
module tb_imem_loader;
  logic clk = 0, rst_n = 0, start = 0, byte_valid = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, cpu_hold, done, error;
  logic [ADDR_W:0] words_loaded;
  logic [0:DEPTH*WORD_W-1] imem;
  int errCnt = 0, chkCnt = 0;
  logic [31:0] expImg [DEPTH];
  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .instructionMemory_data(imem), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] dutWord(input int i);
    return imem[i*32 +: 32];
  endfunction
  task automatic checkImage(input string tag);
    for (int i = 0; i < DEPTH; i++) checkVal($sformatf("%s w%0d", tag, i), dutWord(i), expImg[i]);
  endtask
  task automatic modelClear();
    for (int i = 0; i < DEPTH; i++) expImg[i] = 0;
  endtask
  task automatic sendByte(input logic [7:0] b, input bit stall);
    int n = 0;
    while (stall && $urandom_range(1, 0) == 1) begin
      byte_valid = 0;
      byte_data = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1;
    byte_data = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) checkVal("byte_ready timeout", 0, 1);
    @(negedge clk);
    byte_valid = 0;
  endtask
  task automatic startPulse();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic loadWords(input logic [31:0] w[$], input bit stall);
    int n = w.size();
    startPulse();
    modelClear();
    sendByte(8'(n >> 8), stall);
    sendByte(8'(n), stall);
    foreach (w[i]) begin
      expImg[i] = w[i];
      for (int k = 3; k >= 0; k--) sendByte(8'(w[i] >> (8*k)), stall);
    end
  endtask
  task automatic checkDone(input string tag, input int n);
    checkVal({tag, " done"}, 32'(done), 1);
    checkVal({tag, " cpu_hold"}, 32'(cpu_hold), 0);
    checkVal({tag, " error"}, 32'(error), 0);
    checkVal({tag, " byte_ready"}, 32'(byte_ready), 0);
    checkVal({tag, " words_loaded"}, 32'(words_loaded), 32'(n));
    checkImage(tag);
  endtask
  task automatic badHeader(input string tag, input logic [7:0] hi, input logic [7:0] lo);
    startPulse();
    sendByte(hi, 1);
    sendByte(lo, 1);
    checkVal({tag, " error"}, 32'(error), 1);
    checkVal({tag, " cpu_hold"}, 32'(cpu_hold), 1);
    checkVal({tag, " byte_ready"}, 32'(byte_ready), 0);
    checkVal({tag, " done"}, 32'(done), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] w[$];
    repeat (3) @(negedge clk);
    modelClear();
    checkVal("rst cpu_hold", 32'(cpu_hold), 1);
    checkVal("rst done", 32'(done), 0);
    checkVal("rst error", 32'(error), 0);
    checkVal("rst byte_ready", 32'(byte_ready), 0);
    checkVal("rst words_loaded", 32'(words_loaded), 0);
    checkImage("rst");
    rst_n = 1;
    @(negedge clk);
    checkVal("idle byte_ready", 32'(byte_ready), 0);
    w = '{32'h12345678, 32'hDEADBEEF};
    loadWords(w, 0);
    checkDone("two", 2);
    loadWords(w, 1);
    checkDone("two stall", 2);
    badHeader("len0", 8'h00, 8'h00);
    w = '{32'($urandom), 32'($urandom), 32'($urandom)};
    loadWords(w, 1);
    checkDone("recover0", 3);
    badHeader("len257", 8'h01, 8'h01);
    badHeader("lenhi", 8'($urandom_range(255, 2)), 8'($urandom));
    w = '{32'($urandom)};
    loadWords(w, 1);
    checkDone("recover1", 1);
    w = {};
    for (int i = 0; i < DEPTH; i++) w.push_back(32'(i) * 32'h01010101);
    loadWords(w, 0);
    checkDone("full", 256);
    checkVal("full w255", dutWord(255), 32'hFFFFFFFF);
    for (int t = 0; t < 4; t++) begin
      int n = $urandom_range(20, 1);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      loadWords(w, 1);
      checkDone($sformatf("rand%0d", t), n);
    end
    startPulse();
    modelClear();
    checkVal("restart done", 32'(done), 0);
    checkVal("restart w0", dutWord(0), 0);
    sendByte(8'h00, 0);
    sendByte(8'h03, 0);
    foreach (w[i]) if (i == 0) w[i] = 32'h11223344;
    for (int k = 0; k < 4; k++) sendByte(8'h11 * 8'(k + 1), 1);
    checkVal("mid wl", 32'(words_loaded), 1);
    checkVal("mid w0", dutWord(0), 32'h11223344);
    startPulse();
    checkVal("mid start wl", 32'(words_loaded), 1);
    checkVal("mid start ready", 32'(byte_ready), 1);
    checkVal("mid start w0", dutWord(0), 32'h11223344);
    sendByte(8'h55, 1);
    sendByte(8'h66, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    checkVal("midrst cpu_hold", 32'(cpu_hold), 1);
    checkVal("midrst done", 32'(done), 0);
    checkVal("midrst ready", 32'(byte_ready), 0);
    checkVal("midrst wl", 32'(words_loaded), 0);
    checkImage("midrst");
    w = '{32'hAAAAAAAA};
    loadWords(w, 0);
    checkDone("aa", 1);
    startPulse();
    modelClear();
    checkVal("reload done low", 32'(done), 0);
    checkVal("reload hold", 32'(cpu_hold), 1);
    sendByte(8'h00, 1);
    sendByte(8'h01, 1);
    checkVal("reload mid done", 32'(done), 0);
    expImg[0] = 32'h55555555;
    for (int k = 0; k < 4; k++) sendByte(8'h55, 1);
    checkDone("55", 1);
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
